// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Optional write-back bypass into the operand capture path is enabled by ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       regf_rdata1,
  input  logic [31:0]       regf_rdata2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_waddr,
  input  logic [31:0]       wb_wdata,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [31:0]       ex_pc_q, ex_pc_d;
  logic [31:0]       ex_imm_q, ex_imm_d;
  logic [31:0]       ex_op1_q, ex_op1_d;
  logic [31:0]       ex_op2_q, ex_op2_d;
  logic [4:0]        ex_rs1_q, ex_rs1_d;
  logic [4:0]        ex_rs2_q, ex_rs2_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic [31:0]       op1_sel, op2_sel;

  always_comb begin
    hazard_stall = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                    (id_use_rs2 & (id_rs2 == ex_rd_q)));
  end

`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    op1_sel = regf_rdata1;
    op2_sel = regf_rdata2;
    if (wb_reg_write && (wb_waddr != '0) && (wb_waddr == id_rs1)) op1_sel = wb_wdata;
    if (wb_reg_write && (wb_waddr != '0) && (wb_waddr == id_rs2)) op2_sel = wb_wdata;
    if (id_rs1 == '0) op1_sel = '0;
    if (id_rs2 == '0) op2_sel = '0;
  end
`else
  // Register file writes on the falling edge, so read data is already current.
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_waddr, wb_wdata};

  always_comb begin
    op1_sel = (id_rs1 == '0) ? '0 : regf_rdata1;
    op2_sel = (id_rs2 == '0) ? '0 : regf_rdata2;
  end
`endif

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_pc_d        = ex_pc_q;
    ex_imm_d       = ex_imm_q;
    ex_op1_d       = ex_op1_q;
    ex_op2_d       = ex_op2_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_ctrl_d      = ex_ctrl_q;
    bubble_cnt_d   = bubble_cnt_q;

    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_ctrl_d      = '0;
    end else if (stall_in) begin
      // hold everything
    end else if (hazard_stall) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_ctrl_d      = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_valid & id_reg_write;
      ex_mem_read_d  = id_valid & id_mem_read;
      ex_ctrl_d      = id_valid ? id_ctrl : '0;
      ex_pc_d        = id_pc;
      ex_imm_d       = id_imm;
      ex_op1_d       = op1_sel;
      ex_op2_d       = op2_sel;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_rd_d        = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_pc_q        <= ex_pc_d;
      ex_imm_q       <= ex_imm_d;
      ex_op1_q       <= ex_op1_d;
      ex_op2_q       <= ex_op2_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_ctrl_q      <= ex_ctrl_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_pc        = ex_pc_q;
  assign ex_imm       = ex_imm_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CTRL_W, default 12, width of the opaque decode control bundle carried to EX.
REQ-002 Parameter CNT_W, default 16, width of the load-use bubble counter.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall_in  input  1  downstream stall; hold EX register contents.
REQ-006 flush  input  1  branch/jump redirect; kill the instruction entering EX.
REQ-007 id_valid  input  1  ID-stage instruction valid.
REQ-008 id_pc, id_imm  input  32 each  PC and sign-extended immediate of the ID instruction.
REQ-009 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-010 id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-011 id_reg_write, id_mem_read  input  1 each  write-back enable and load flag.
REQ-012 id_ctrl  input  CTRL_W  remaining decode controls, passed through unmodified.
REQ-013 regf_rdata1, regf_rdata2  input  32 each  register-file read data for rs1/rs2.
REQ-014 wb_reg_write  input  1; wb_waddr  input  5; wb_wdata  input  32  write-back port, same values driven to the register file.
REQ-015 hazard_stall  output  1  combinational load-use stall request to PC/IF-ID.
REQ-016 ex_valid, ex_reg_write, ex_mem_read  output  1 each; ex_pc, ex_imm, ex_op1, ex_op2  output  32 each; ex_rs1, ex_rs2, ex_rd  output  5 each; ex_ctrl  output  CTRL_W  registered EX-stage bundle.
REQ-017 bubble_cnt  output  CNT_W  count of load-use bubbles inserted.

Function
REQ-018 hazard_stall SHALL equal ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-019 Per rising edge, priority SHALL be flush > stall_in > hazard_stall > capture.
REQ-020 flush: ex_valid, ex_reg_write, ex_mem_read, ex_ctrl <= 0; data fields may hold; bubble_cnt unchanged.
REQ-021 stall_in (no flush): every EX register and bubble_cnt SHALL hold.
REQ-022 hazard_stall (no flush, no stall_in): insert bubble (ex_valid, ex_reg_write, ex_mem_read, ex_ctrl <= 0) and bubble_cnt increments by 1, saturating at all-ones.
REQ-023 Capture: all ex_* fields <= corresponding id_* fields, ex_op1/ex_op2 <= selected operands; ex_reg_write, ex_mem_read, ex_ctrl SHALL be forced to 0 when id_valid = 0.
REQ-024 Latency SHALL be exactly one cycle from ID inputs to ex_* outputs; no internal buffering beyond one entry.
REQ-025 An operand whose source index is 0 SHALL be captured as 32'h0 regardless of read or bypass data.
REQ-026 Hazard comparison SHALL use ex_* register values from before the edge; a flush the same cycle still drives hazard_stall but no bubble is counted.

Reset
REQ-027 While rst = 0, all ex_* outputs and bubble_cnt SHALL be 0 immediately, independent of clk.
REQ-028 hazard_stall SHALL be 0 during reset (follows from ex_valid = 0).
REQ-029 Release of rst SHALL take effect at the next rising clk; first capture occurs on that edge.

Configuration
REQ-030 Macro ID_EX_WB_BYPASS_EN: when defined, operand n SHALL be wb_wdata if wb_reg_write & wb_waddr != 0 & wb_waddr == id_rsn, else regf_rdatan.
REQ-031 Without ID_EX_WB_BYPASS_EN, operands SHALL be regf_rdata1/regf_rdata2 directly (relying on negedge register-file write), and wb_* inputs are unused.

Verification
REQ-032 Reset: assert rst=0 mid-cycle with ex_valid=1 -> all outputs 0 before next edge, bubble_cnt=0.
REQ-033 Plain capture: id_valid=1, id_pc=0x100, regf_rdata1=0xAAAA5555, id_rs1=3 -> next cycle ex_pc=0x100, ex_op1=0xAAAA5555, ex_valid=1.
REQ-034 Load-use: EX holds load rd=5, ID reads rs2=5 -> hazard_stall=1, next cycle ex_valid=0, bubble_cnt=1; rd=0 load -> no stall.
REQ-035 Priority: flush=1 and stall_in=1 together -> ex_valid=0; stall_in alone with hazard -> all EX regs and bubble_cnt hold.
REQ-036 Bypass (macro defined): wb_reg_write=1, wb_waddr=7, wb_wdata=0x12345678, id_rs1=7, regf_rdata1=0 -> ex_op1=0x12345678; same with id_rs1=0 -> ex_op1=0.
REQ-037 Saturation: force CNT_W=4, 20 consecutive hazards -> bubble_cnt stops at 4'hF.
